// File: rtl/shift_pkg.sv
// Shared types for the iterative shift unit: shift modes and FSM states.
package shift_pkg;

    typedef enum logic [1:0] {
        SH_ASR = 2'b00,
        SH_LSR = 2'b01,
        SH_LSL = 2'b10,
        SH_ROR = 2'b11
    } shift_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } shift_state_e;

endpackage

// File: rtl/shift_step.sv
// Combinational single-bit shift in one of four modes; out_bit is the bit dropped off the end.
module shift_step
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] din,
    input  shift_mode_e      mode,
    output logic [WIDTH-1:0] dout,
    output logic             out_bit
);

    always_comb begin
        dout    = din;
        out_bit = 1'b0;
        unique case (mode)
            SH_ASR: begin
                dout    = {din[WIDTH-1], din[WIDTH-1:1]};
                out_bit = din[0];
            end
            SH_LSR: begin
                dout    = {1'b0, din[WIDTH-1:1]};
                out_bit = din[0];
            end
            SH_LSL: begin
                dout    = {din[WIDTH-2:0], 1'b0};
                out_bit = din[WIDTH-1];
            end
            // Rotation loses nothing, so it never contributes to sticky.
            SH_ROR: begin
                dout    = {din[0], din[WIDTH-1:1]};
                out_bit = 1'b0;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/iterative_shift_unit.sv
// Multi-mode shifter doing one bit per cycle for a programmable count, then pulsing done.
// Optional SHIFT_STICKY_EN adds a sticky output (OR of all bits shifted out).
module iterative_shift_unit
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned AMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    input  logic [AMT_W-1:0] amount,
    input  logic [1:0]       mode,
    output logic             busy,
    output logic             done,
`ifdef SHIFT_STICKY_EN
    output logic             sticky,
`endif
    output logic [WIDTH-1:0] dout
);

    shift_state_e     state_q, state_d;
    logic [WIDTH-1:0] sreg_q;
    logic [AMT_W-1:0] cnt_q;
    shift_mode_e      mode_q;
    logic [WIDTH-1:0] dout_q;

    logic [WIDTH-1:0] step_out;
    logic             step_bit;
    logic             accept;
    logic             last_shift;

    assign accept     = (state_q == ST_IDLE) && start;
    assign last_shift = (state_q == ST_SHIFT) && (cnt_q == AMT_W'(1));

    shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .din     (sreg_q),
        .mode    (mode_q),
        .dout    (step_out),
        .out_bit (step_bit)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (amount != '0) ? ST_SHIFT : ST_DONE;
                end
            end
            ST_SHIFT: begin
                if (cnt_q == AMT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = (state_q != ST_IDLE);
        done = (state_q == ST_DONE);
    end

    // Datapath: operand capture, shifting, and result update on the way into DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg_q <= '0;
            cnt_q  <= '0;
            mode_q <= SH_ASR;
            dout_q <= '0;
        end else if (accept) begin
            sreg_q <= din;
            cnt_q  <= amount;
            mode_q <= shift_mode_e'(mode);
            if (amount == '0) begin
                dout_q <= din;
            end
        end else if (state_q == ST_SHIFT) begin
            sreg_q <= step_out;
            cnt_q  <= cnt_q - AMT_W'(1);
            if (last_shift) begin
                dout_q <= step_out;
            end
        end
    end

    assign dout = dout_q;

`ifdef SHIFT_STICKY_EN
    logic sticky_acc_q;
    logic sticky_q;

    // Accumulator tracks the running op; sticky_q is published alongside dout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_acc_q <= 1'b0;
            sticky_q     <= 1'b0;
        end else if (accept) begin
            sticky_acc_q <= 1'b0;
            if (amount == '0) begin
                sticky_q <= 1'b0;
            end
        end else if (state_q == ST_SHIFT) begin
            sticky_acc_q <= sticky_acc_q | step_bit;
            if (last_shift) begin
                sticky_q <= sticky_acc_q | step_bit;
            end
        end
    end

    assign sticky = sticky_q;
`else
    logic unused_step_bit;
    assign unused_step_bit = step_bit;
`endif

endmodule
